// File: rtl/fp_div_stall_wrapper.sv
// rtl/fp_div_stall_wrapper.sv - elastic stall pipeline around a combinational single-precision divider
package apu_cluster_package;
    localparam int FP_WIDTH     = 32;
    localparam int SIG_WIDTH    = 23;
    localparam int EXP_WIDTH    = 8;
    localparam int IEEE_COMP    = 0;
    localparam int NDSFLAGS_DIV = 3;
    localparam int NUSFLAGS_DIV = 8;
endpackage

module fp_div_stall_wrapper
    import apu_cluster_package::*;
#(
    parameter int NUM_PRE_REGS  = 2,
    parameter int NUM_POST_REGS = 1,
    parameter int TAG_WIDTH     = 4,
    parameter int RND_WIDTH     = NDSFLAGS_DIV,
    parameter int STAT_WIDTH    = NUSFLAGS_DIV
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  En_i,
    output logic                  Ready_o,
    input  logic [FP_WIDTH-1:0]   OpA_i,
    input  logic [FP_WIDTH-1:0]   OpB_i,
    input  logic [RND_WIDTH-1:0]  Rnd_i,
    input  logic [TAG_WIDTH-1:0]  Tag_i,
    input  logic                  Flush_i,
    output logic                  Valid_o,
    input  logic                  Ready_i,
    output logic [FP_WIDTH-1:0]   Res_o,
    output logic [STAT_WIDTH-1:0] Status_o,
    output logic [TAG_WIDTH-1:0]  Tag_o,
    output logic                  Busy_o
);

    localparam int N = NUM_PRE_REGS + NUM_POST_REGS;

    if (NUM_PRE_REGS < 0 || NUM_PRE_REGS > 4 || NUM_POST_REGS < 0 || NUM_POST_REGS > 4 ||
        TAG_WIDTH < 1 || STAT_WIDTH < 8 || IEEE_COMP != 0) begin : g_bad_params
        $error("fp_div_stall_wrapper: unsupported parameter combination");
    end

    // Global stage valids: bit 0 is the input port, bit k is stage k (pre stages first).
    logic [N:0] vld_v;
    logic [N:0] rdy;
    logic       busy;

    logic [FP_WIDTH-1:0]   pre_a   [NUM_PRE_REGS+1];
    logic [FP_WIDTH-1:0]   pre_b   [NUM_PRE_REGS+1];
    logic [RND_WIDTH-1:0]  pre_rnd [NUM_PRE_REGS+1];
    logic [TAG_WIDTH-1:0]  pre_tag [NUM_PRE_REGS+1];
    logic [FP_WIDTH-1:0]   post_res  [NUM_POST_REGS+1];
    logic [STAT_WIDTH-1:0] post_stat [NUM_POST_REGS+1];
    logic [TAG_WIDTH-1:0]  post_tag  [NUM_POST_REGS+1];

    logic [FP_WIDTH-1:0]   core_res;
    logic [STAT_WIDTH-1:0] core_stat;

    assign vld_v[0]   = En_i;
    assign pre_a[0]   = En_i ? OpA_i : '0;
    assign pre_b[0]   = En_i ? OpB_i : '0;
    assign pre_rnd[0] = Rnd_i;
    assign pre_tag[0] = Tag_i;

    always_comb begin
        rdy    = '0;
        busy   = 1'b0;
        rdy[N] = Ready_i;
        for (int k = N; k >= 1; k--) begin
            rdy[k-1] = !vld_v[k] || rdy[k];
            busy     = busy | vld_v[k];
        end
    end

    for (genvar k = 1; k <= NUM_PRE_REGS; k++) begin : g_pre
        logic                 vld_q;
        logic [FP_WIDTH-1:0]  a_q;
        logic [FP_WIDTH-1:0]  b_q;
        logic [RND_WIDTH-1:0] rnd_q;
        logic [TAG_WIDTH-1:0] tag_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                vld_q <= 1'b0;
                a_q   <= '0;
                b_q   <= '0;
                rnd_q <= '0;
                tag_q <= '0;
            end else if (Flush_i) begin
                vld_q <= 1'b0;
            end else if (rdy[k-1]) begin
                vld_q <= vld_v[k-1];
                if (vld_v[k-1]) begin
                    a_q   <= pre_a[k-1];
                    b_q   <= pre_b[k-1];
                    rnd_q <= pre_rnd[k-1];
                    tag_q <= pre_tag[k-1];
                end
            end
        end

        assign vld_v[k]   = vld_q;
        assign pre_a[k]   = a_q;
        assign pre_b[k]   = b_q;
        assign pre_rnd[k] = rnd_q;
        assign pre_tag[k] = tag_q;
    end

    assign post_res[0]  = core_res;
    assign post_stat[0] = core_stat;
    assign post_tag[0]  = pre_tag[NUM_PRE_REGS];

    for (genvar j = 1; j <= NUM_POST_REGS; j++) begin : g_post
        localparam int G = NUM_PRE_REGS + j;
        logic                  vld_q;
        logic [FP_WIDTH-1:0]   res_q;
        logic [STAT_WIDTH-1:0] stat_q;
        logic [TAG_WIDTH-1:0]  tag_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                vld_q  <= 1'b0;
                res_q  <= '0;
                stat_q <= '0;
                tag_q  <= '0;
            end else if (Flush_i) begin
                vld_q <= 1'b0;
            end else if (rdy[G-1]) begin
                vld_q <= vld_v[G-1];
                if (vld_v[G-1]) begin
                    res_q  <= post_res[j-1];
                    stat_q <= post_stat[j-1];
                    tag_q  <= post_tag[j-1];
                end
            end
        end

        assign vld_v[G]     = vld_q;
        assign post_res[j]  = res_q;
        assign post_stat[j] = stat_q;
        assign post_tag[j]  = tag_q;
    end

    assign Ready_o  = rdy[0] && !Flush_i;
    assign Valid_o  = vld_v[N];
    assign Res_o    = post_res[NUM_POST_REGS];
    assign Status_o = post_stat[NUM_POST_REGS];
    assign Tag_o    = post_tag[NUM_POST_REGS];
    assign Busy_o   = busy;

`ifdef FP_SIM_MODELS
    always_comb begin
        core_res  = $shortrealtobits($bitstoshortreal(pre_a[NUM_PRE_REGS]) /
                                     $bitstoshortreal(pre_b[NUM_PRE_REGS]));
        core_stat = '0;
    end
`else
    // Status layout: 0 zero, 1 inf, 2 invalid, 3 tiny, 4 huge, 5 inexact, 7 divide-by-zero.
    localparam int MW   = SIG_WIDTH + 1;
    localparam int QW   = MW + 3;
    localparam int NW   = MW + QW - 1;
    localparam int EW2  = EXP_WIDTH + 3;
    localparam int BIAS = 2 ** (EXP_WIDTH - 1) - 1;
    localparam int EMAX = 2 ** EXP_WIDTH - 1;

    logic                 sa, sb, sign;
    logic [EXP_WIDTH-1:0] ea, eb;
    logic [SIG_WIDTH-1:0] fa, fb;
    logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [NW-1:0]        num, den;
    logic [QW-1:0]        quo;
    logic [MW-1:0]        rem;
    logic                 norm, guard, sticky, inexact, inc, to_inf;
    logic [SIG_WIDTH-1:0] frac;
    logic [SIG_WIDTH:0]   frac_r;
    logic [EW2-1:0]       e_r;
    logic                 ovf, unf;
    logic [RND_WIDTH-1:0] rnd;

    assign {sa, ea, fa} = pre_a[NUM_PRE_REGS];
    assign {sb, eb, fb} = pre_b[NUM_PRE_REGS];
    assign rnd    = pre_rnd[NUM_PRE_REGS];
    assign sign   = sa ^ sb;
    // Subnormal inputs are flushed to zero.
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == '1) && (fa == '0);
    assign b_inf  = (eb == '1) && (fb == '0);
    assign a_nan  = (ea == '1) && (fa != '0);
    assign b_nan  = (eb == '1) && (fb != '0);

    // Mantissa ratio lies in (0.5, 2), so the quotient MSB sits at bit QW-1 or QW-2.
    assign num    = {1'b1, fa, {(QW-1){1'b0}}};
    assign den    = {{(QW-1){1'b0}}, 1'b1, fb};
    assign quo    = QW'(num / den);
    assign rem    = MW'(num % den);
    assign norm   = quo[QW-1];
    assign frac   = norm ? quo[SIG_WIDTH+2:3] : quo[SIG_WIDTH+1:2];
    assign guard  = norm ? quo[2] : quo[1];
    assign sticky = (norm ? (|quo[1:0]) : quo[0]) | (|rem);
    assign inexact = guard | sticky;

    always_comb begin
        inc    = guard & (sticky | frac[0]);
        to_inf = 1'b1;
        case (int'(rnd))
            1: begin inc = 1'b0;              to_inf = 1'b0;  end
            2: begin inc = !sign & inexact;   to_inf = !sign; end
            3: begin inc = sign & inexact;    to_inf = sign;  end
            4: begin inc = guard;             to_inf = 1'b1;  end
            5: begin inc = inexact;           to_inf = 1'b1;  end
            default: ;
        endcase
    end

    assign frac_r = {1'b0, frac} + {{SIG_WIDTH{1'b0}}, inc};
    assign e_r    = {3'b000, ea} + EW2'(BIAS) - {3'b000, eb} - EW2'(!norm) + EW2'(frac_r[SIG_WIDTH]);
    assign ovf    = !e_r[EW2-1] && (e_r >= EW2'(EMAX));
    assign unf    = e_r[EW2-1] || (e_r == '0);

    always_comb begin
        core_res  = '0;
        core_stat = '0;
        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
            core_res     = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(SIG_WIDTH-1){1'b0}}};
            core_stat[2] = 1'b1;
        end else if (a_inf || b_zero) begin
            core_res     = {sign, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
            core_stat[1] = 1'b1;
            core_stat[7] = b_zero && !a_inf;
        end else if (a_zero || b_inf) begin
            core_res     = {sign, {(FP_WIDTH-1){1'b0}}};
            core_stat[0] = 1'b1;
        end else if (ovf) begin
            core_stat[4] = 1'b1;
            core_stat[5] = 1'b1;
            core_stat[1] = to_inf;
            core_res     = to_inf ? {sign, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}}
                                  : {sign, {(EXP_WIDTH-1){1'b1}}, 1'b0, {SIG_WIDTH{1'b1}}};
        end else if (unf) begin
            core_res     = {sign, {(FP_WIDTH-1){1'b0}}};
            core_stat[0] = 1'b1;
            core_stat[3] = 1'b1;
            core_stat[5] = 1'b1;
        end else begin
            core_res     = {sign, e_r[EXP_WIDTH-1:0], frac_r[SIG_WIDTH-1:0]};
            core_stat[5] = inexact;
        end
    end
`endif

endmodule

// File: doc/fp_div_stall_wrapper.md
FP_DIV_STALL_WRAPPER -- requirements
Module: fp_div_stall_wrapper

Interface
REQ-001 SHALL have parameter NUM_PRE_REGS, default 2, register stages before the divide core (0..4).
REQ-002 SHALL have parameter NUM_POST_REGS, default 1, register stages after the divide core (0..4).
REQ-003 SHALL have parameter TAG_WIDTH, default 4, width of the tag carried with each operation (>=1).
REQ-004 SHALL have parameter RND_WIDTH, default 3, and STAT_WIDTH, default 8, sized to NDSFLAGS_DIV/NUSFLAGS_DIV.
REQ-005 SHALL take FP_WIDTH, SIG_WIDTH, EXP_WIDTH and IEEE_COMP from apu_cluster_package.
REQ-006 SHALL have ports:
 clk_i  in  1  clock, all state on rising edge
 rst_i  in  1  synchronous active-high reset
 En_i  in  1  input operation valid
 Ready_o  out  1  input accepted this cycle when En_i && Ready_o
 OpA_i  in  FP_WIDTH  dividend
 OpB_i  in  FP_WIDTH  divisor
 Rnd_i  in  RND_WIDTH  rounding mode
 Tag_i  in  TAG_WIDTH  operation tag
 Flush_i  in  1  drop all in-flight operations
 Valid_o  out  1  result valid
 Ready_i  in  1  consumer accepts result when Valid_o && Ready_i
 Res_o  out  FP_WIDTH  quotient
 Status_o  out  STAT_WIDTH  core status flags
 Tag_o  out  TAG_WIDTH  tag of the result
 Busy_o  out  1  any stage holds a valid operation

Function
REQ-007 SHALL form an elastic pipeline of N = NUM_PRE_REGS + NUM_POST_REGS stages, each with its own valid bit.
REQ-008 SHALL compute stage ready as ready[k] = !valid[k] || ready[k+1], with ready[N+1] = Ready_i; Ready_o = ready[1].
REQ-009 SHALL load a stage (data and valid) only when ready[k]; a stalled stage SHALL hold data, tag, rnd and status unchanged.
REQ-010 SHALL gate data loads by upstream valid: a stage whose upstream is invalid clears its valid bit but keeps its data registers.
REQ-011 SHALL zero OpA/OpB entering stage 1 when En_i is low, so the core sees zero operands on idle cycles.
REQ-012 SHALL place the divide core (DW_fp_div; with FP_SIM_MODELS, a shortreal a/b model with Status forced to 0) combinationally between the last pre stage and the first post stage.
REQ-013 SHALL give latency exactly N cycles from acceptance to Valid_o with Ready_i held high, at a throughput of one operation per cycle.
REQ-014 SHALL, when N = 0, pass through combinationally: Valid_o = En_i, Ready_o = Ready_i, Res_o = core output.
REQ-015 SHALL hold Res_o, Status_o and Tag_o stable while Valid_o && !Ready_i.
REQ-016 SHALL preserve operation order; tags SHALL emerge in acceptance order.
REQ-017 SHALL, on Flush_i, clear all valid bits at the next edge; Ready_o SHALL be forced low during the Flush_i cycle, so no input is accepted.
REQ-018 SHALL drive Busy_o as the OR of all stage valid bits.
REQ-019 SHALL give a Flush_i and an En_i in the same cycle flush priority: the input is not accepted.

Reset
REQ-020 SHALL, when rst_i is high at a clock edge, clear all valid bits and all data, tag, rnd and status registers to 0.
REQ-021 SHALL hold after reset: Valid_o=0, Busy_o=0, Res_o=0, Status_o=0, Tag_o=0, Ready_o=1 (for N>0).
REQ-022 SHALL give reset asserted mid-operation priority over all other inputs, discarding in-flight work with no output.

Verification
REQ-023 Defaults, Ready_i=1: OpA=0x40C00000 (6.0), OpB=0x40000000, Tag=5, one cycle -> Valid_o exactly 3 cycles later, Res_o=0x40400000, Tag_o=5.
REQ-024 Back-to-back: tags 1,2,3 on consecutive cycles, Ready_i=1 -> Valid_o high 3 consecutive cycles with tags 1,2,3, Ready_o never low.
REQ-025 Back-pressure: Ready_i=0, issue 4 ops -> 3 accepted, Ready_o low from 4th cycle, Res_o/Tag_o of op 1 stable; raise Ready_i -> all 3 drain in order, then the 4th is accepted.
REQ-026 Divide by zero: 1.0/0.0 (0x3F800000/0x00000000) -> Res_o=0x7F800000 and the divide-by-zero bit (Status_o[7]) set (non-sim build).
REQ-027 Flush with 2 in flight -> Busy_o=0 next cycle, no Valid_o ever appears; a Flush_i+En_i cycle -> Ready_o=0, the op is dropped.
REQ-028 rst_i pulsed 1 cycle with 3 ops in flight -> all outputs 0 next cycle, no stale Valid_o; a new op afterwards returns after 3 cycles.
